// File: rtl/unidade_controle_param.sv
// Parametrised control unit for the memory-sequence game.
// Owns the address (E), round (L) and timer (T) counters. Supports an
// optional sequence-demonstration phase before each round and an optional
// write phase where the player appends a new move after each cleared round.
module unidade_controle_param #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SHOW_CYCLES    = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic              modo_demo,
  input  logic              modo_escrita,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              escreveM,
  output logic              mostra,
  output logic              acertou,
  output logic              errou,
  output logic              pronto,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  localparam int MAXC = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] T_TO_END = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_SH_END = TW'(SHOW_CYCLES - 1);

  // State codes are visible on db_estado, so they are fixed explicitly.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    INICIALIZA     = 4'd1,
    INICIA_RODADA  = 4'd2,
    MOSTRA         = 4'd3,
    ESPERA         = 4'd4,
    REGISTRA       = 4'd5,
    COMPARA        = 4'd6,
    PASSA          = 4'd7,
    PAUSA          = 4'd8,
    ESPERA_ESCRITA = 4'd9,
    REG_ESCRITA    = 4'd10,
    ESCREVE        = 4'd11,
    FIM_RODADA     = 4'd12,
    ERRO           = 4'd14,
    ACERTO         = 4'd15
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] e_q, e_d;
  logic [ADDR_W-1:0] l_q, l_d;
  logic [TW-1:0]     t_q, t_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic              demo_q, demo_d;
  logic              escr_q, escr_d;
  logic              to_q, to_d;

  // State, counters and latched game configuration.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      e_q     <= '0;
      l_q     <= '0;
      t_q     <= '0;
      lim_q   <= '0;
      demo_q  <= 1'b0;
      escr_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      l_q     <= l_d;
      t_q     <= t_d;
      lim_q   <= lim_d;
      demo_q  <= demo_d;
      escr_q  <= escr_d;
      to_q    <= to_d;
    end
  end

  // Next state and counter updates; jogada takes priority over the timer's terminal count.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    l_d     = l_q;
    t_d     = t_q;
    lim_d   = lim_q;
    demo_d  = demo_q;
    escr_d  = escr_q;
    to_d    = to_q;
    case (state_q)
      INICIAL: begin
        if (iniciar) state_d = INICIALIZA;
      end
      INICIALIZA: begin
        e_d     = '0;
        l_d     = '0;
        t_d     = '0;
        lim_d   = limite;
        demo_d  = modo_demo;
        escr_d  = modo_escrita;
        to_d    = 1'b0;
        state_d = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        e_d     = '0;
        t_d     = '0;
        state_d = demo_q ? MOSTRA : ESPERA;
      end
      MOSTRA: begin
        if (t_q == T_SH_END) begin
          t_d     = '0;
          state_d = PAUSA;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      PAUSA: begin
        if (t_q == T_SH_END) begin
          t_d = '0;
          if (e_q == l_q) begin
            e_d     = '0;
            state_d = ESPERA;
          end else begin
            e_d     = e_q + 1'b1;
            state_d = MOSTRA;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ESPERA, ESPERA_ESCRITA: begin
        if (jogada) begin
          t_d     = '0;
          state_d = (state_q == ESPERA) ? REGISTRA : REG_ESCRITA;
        end else if (t_q == T_TO_END) begin
          to_d    = 1'b1;
          state_d = ERRO;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      REGISTRA: begin
        state_d = COMPARA;
      end
      COMPARA: begin
        if (!igual) begin
          to_d    = 1'b0;
          state_d = ERRO;
        end else if (e_q < l_q) begin
          state_d = PASSA;
        end else if (l_q == lim_q) begin
          state_d = ACERTO;
        end else if (escr_q) begin
          t_d     = '0;
          state_d = ESPERA_ESCRITA;
        end else begin
          state_d = FIM_RODADA;
        end
      end
      PASSA: begin
        e_d     = e_q + 1'b1;
        t_d     = '0;
        state_d = ESPERA;
      end
      REG_ESCRITA: begin
        state_d = ESCREVE;
      end
      ESCREVE: begin
        state_d = FIM_RODADA;
      end
      FIM_RODADA: begin
        if (l_q == lim_q) begin
          state_d = ACERTO;
        end else begin
          l_d     = l_q + 1'b1;
          state_d = INICIA_RODADA;
        end
      end
      ACERTO, ERRO: begin
        if (iniciar) state_d = INICIALIZA;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // Moore outputs; the write phase addresses the slot just past the current round.
  always_comb begin
    zeraR     = 1'b0;
    registraR = 1'b0;
    escreveM  = 1'b0;
    mostra    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    pronto    = 1'b0;
    timeout   = 1'b0;
    endereco  = e_q;
    case (state_q)
      INICIAL, INICIALIZA: zeraR = 1'b1;
      MOSTRA:              mostra = 1'b1;
      REGISTRA:            registraR = 1'b1;
      ESPERA_ESCRITA:      endereco = l_q + 1'b1;
      REG_ESCRITA: begin
        registraR = 1'b1;
        endereco  = l_q + 1'b1;
      end
      ESCREVE: begin
        escreveM = 1'b1;
        endereco = l_q + 1'b1;
      end
      ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      ERRO: begin
        errou   = 1'b1;
        pronto  = 1'b1;
        timeout = to_q;
      end
      default: ;
    endcase
  end

  assign rodada    = l_q;
  assign db_estado = state_q;

endmodule

// File: doc/unidade_controle_param.md
Name: unidade_controle_param

Overview:
- Parametrised control unit for the memory-sequence game. It is the successor of the fixed four-status-input controller.
- Owns its own address counter (E), round counter (L) and timeout counter (T); it no longer depends on datapath counters.
- Adds a sequence-demonstration mode (plays the stored sequence before each round) and a write mode (player appends a new move to memory at the end of each round).
- Sits between the game datapath (memory, jogada register, comparator) and the top level.

Parameters:
- ADDR_W, 4: width of the address/round counters; maximum sequence length is 2^ADDR_W.
- TIMEOUT_CYCLES, 5000: cycles allowed in each wait state before timeout (>=2).
- SHOW_CYCLES, 1000: cycles each LED is lit in demonstration, and the length of each dark gap (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- iniciar  in  1  start/restart game
- jogada  in  1  one-cycle pulse: player move valid
- igual  in  1  datapath comparator: registered move == memory[endereco]
- modo_demo  in  1  1 = demonstrate sequence before each round
- modo_escrita  in  1  1 = player appends a move after each cleared round
- limite  in  ADDR_W  index of the last round
- endereco  out  ADDR_W  memory address
- rodada  out  ADDR_W  current round index L
- zeraR  out  1  clear move register
- registraR  out  1  load move register
- escreveM  out  1  memory write enable
- mostra  out  1  drive LEDs from memory[endereco]
- acertou / errou / pronto  out  1 each  game result flags
- timeout  out  1  set when errou was caused by timeout
- db_estado  out  4  current state code

Behaviour:
- Reset (async, reset=0): state INICIAL; E=L=T=0; latched limite/modes cleared; all outputs 0 except zeraR=1.
- All outputs are Moore outputs decoded from the state, except endereco. endereco = E everywhere except ESPERA_ESCRITA/REG_ESCRITA/ESCREVE, where it is L+1.
- Inputs limite, modo_demo and modo_escrita are latched in INICIALIZA only. Changing them mid-game has no effect.
- States (db_estado):
  - INICIAL(0): zeraR=1. iniciar -> INICIALIZA.
  - INICIALIZA(1): zeraR=1; E,L,T <= 0; latch inputs. -> INICIA_RODADA.
  - INICIA_RODADA(2): E,T <= 0. -> MOSTRA if modo_demo, else ESPERA.
  - MOSTRA(3): mostra=1; T counts. At T==SHOW_CYCLES-1: T<=0 -> PAUSA.
  - PAUSA(8): mostra=0; T counts. At T==SHOW_CYCLES-1: T<=0; if E==L then E<=0 -> ESPERA, else E++ -> MOSTRA.
  - ESPERA(4): T counts.
    - jogada -> REGISTRA, T<=0. jogada wins if it coincides with the terminal count.
    - Otherwise at T==TIMEOUT_CYCLES-1 -> ERRO with timeout flag set.
  - REGISTRA(5): registraR=1. -> COMPARA.
  - COMPARA(6), evaluated in this order:
    - !igual -> ERRO.
    - E<L -> PASSA.
    - E==L and L==limite -> ACERTO.
    - E==L and modo_escrita -> ESPERA_ESCRITA (T<=0).
    - Otherwise -> FIM_RODADA.
  - PASSA(7): E++, T<=0. -> ESPERA.
  - ESPERA_ESCRITA(9): same jogada/timeout rules as ESPERA. jogada -> REG_ESCRITA.
  - REG_ESCRITA(10): registraR=1. -> ESCREVE.
  - ESCREVE(11): escreveM=1 for exactly one cycle. -> FIM_RODADA.
  - FIM_RODADA(12): L==limite -> ACERTO; else L++ -> INICIA_RODADA.
  - ACERTO(15): acertou=1, pronto=1. iniciar -> INICIALIZA.
  - ERRO(14): errou=1, pronto=1; timeout=1 iff entered from a wait-state timeout. iniciar -> INICIALIZA. The flag clears in INICIALIZA.
- Counter rules:
  - E and L never exceed the latched limite.
  - No wrap is possible, because L+1 is used only when L<limite.
  - T is reset on every state entry that counts. T width = clog2(max(TIMEOUT_CYCLES, SHOW_CYCLES)).
- limite=0 is a one-move game: no write phase, ACERTO after the first correct move.
- jogada outside ESPERA/ESPERA_ESCRITA is ignored.
- iniciar outside INICIAL/ACERTO/ERRO is ignored.
- Reset asserted mid-game returns to INICIAL within the same cycle, with all outputs at reset values.

Test Plan:
- Params ADDR_W=4, TIMEOUT_CYCLES=8, SHOW_CYCLES=2; limite=2, modes 0; correct moves each round -> rounds 0,1,2 complete; acertou=1, pronto=1, db_estado=15; registraR pulses 1+2+3=6 times.
- Same params, igual=0 on second move of round 1 -> ERRO; errou=1, timeout=0, rodada=1.
- No jogada for 8 cycles in ESPERA -> ERRO on the 8th cycle with timeout=1. jogada on cycle 8 exactly -> REGISTRA instead.
- modo_demo=1, limite=1: round 1 shows mostra high 2 cycles at endereco 0, low 2 cycles, high 2 cycles at endereco 1, low 2 cycles, then ESPERA.
- modo_escrita=1, limite=2: after clearing round 0, one escreveM pulse with endereco=1; after round 1, escreveM with endereco=2; after round 2, no write, direct ACERTO.
- reset=0 asserted during MOSTRA -> db_estado=0, mostra=0, zeraR=1 immediately. Then iniciar restarts with rodada=0.
